// File: rtl/cache_control_pkg.sv
// Shared types and helpers for the L1 cache maintenance sequencer.
package cache_control_pkg;

    localparam int unsigned CC_OP_W = 2;

    typedef enum logic [CC_OP_W-1:0] {
        CC_NONE        = 2'b00,
        CC_FLUSH       = 2'b01,
        CC_CLEAR       = 2'b10,
        CC_FLUSH_CLEAR = 2'b11
    } cc_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        CLEAR = 2'd2,
        DONE  = 2'd3
    } cc_state_t;

    function automatic logic op_has_flush(input cc_op_t op);
        return (op == CC_FLUSH) || (op == CC_FLUSH_CLEAR);
    endfunction

    function automatic logic op_has_clear(input cc_op_t op);
        return (op == CC_CLEAR) || (op == CC_FLUSH_CLEAR);
    endfunction

    // A disabled timeout still needs a one-bit counter to keep the ports legal.
    function automatic int unsigned cnt_width(input int unsigned t);
        return (t == 0) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/cc_find_first.sv
// Lowest-set-bit selector: returns a one-hot copy of the least significant set bit.
module cc_find_first #(
    parameter int unsigned W = 2
) (
    input  logic [W-1:0] in_vec,
    output logic [W-1:0] first_c
);

    assign first_c = in_vec & (~in_vec + W'(1));

endmodule

// File: rtl/cache_control_sequencer.sv
// Sequences flush/clear maintenance across a set of L1 caches, flushes strictly
// before clears, with a per-phase (parallel) or per-cache (serial) timeout.
module cache_control_sequencer
    import cache_control_pkg::*;
#(
    parameter int unsigned NUM_CACHES     = 2,
    parameter int unsigned SERIAL         = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  req_valid,
    input  logic [CC_OP_W-1:0]    req_op,
    input  logic [NUM_CACHES-1:0] req_mask,
    output logic                  req_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err,
    output logic [NUM_CACHES-1:0] cache_flush,
    output logic [NUM_CACHES-1:0] cache_clear,
    input  logic [NUM_CACHES-1:0] flush_done,
    input  logic [NUM_CACHES-1:0] clear_done
);

    localparam int unsigned      N           = NUM_CACHES;
    localparam int unsigned      CNT_W       = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(TIMEOUT_CYCLES);
    localparam bit               TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);
    localparam bit               SERIAL_MODE = (SERIAL != 0);

    cc_state_t        state_q, state_d;
    cc_op_t           op_q, op_d;
    logic [N-1:0]     mask_q, mask_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_ready_q, req_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic [N-1:0]     cache_flush_q, cache_flush_d;
    logic [N-1:0]     cache_clear_q, cache_clear_d;

    logic [N-1:0]     ack;
    logic [N-1:0]     pending_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             serial_ack;
    logic [N-1:0]     sel_first;
    logic [N-1:0]     req_sel;

    cc_find_first #(
        .W (N)
    ) u_find_first (
        .in_vec  (pending_d),
        .first_c (sel_first)
    );

    // Next-state, pending-set and timeout counter.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        mask_d      = mask_q;
        pending_d   = pending_q;
        cnt_d       = cnt_q;
        timeout_d   = 1'b0;
        ack         = '0;
        pending_nxt = pending_q;
        serial_ack  = 1'b0;
        cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    op_d   = cc_op_t'(req_op);
                    mask_d = req_mask;
                    cnt_d  = '0;
                    if (op_has_flush(cc_op_t'(req_op)) && (req_mask != '0)) begin
                        state_d   = FLUSH;
                        pending_d = req_mask;
                    end else if (op_has_clear(cc_op_t'(req_op)) && (req_mask != '0)) begin
                        state_d   = CLEAR;
                        pending_d = req_mask;
                    end else begin
                        state_d   = DONE;
                        pending_d = '0;
                    end
                end
            end

            FLUSH, CLEAR: begin
                // Only an acknowledge for a request we are currently driving counts.
                ack         = (state_q == FLUSH) ? (flush_done & cache_flush_q)
                                                 : (clear_done & cache_clear_q);
                pending_nxt = pending_q & ~ack;
                serial_ack  = SERIAL_MODE && (ack != '0);
                pending_d   = pending_nxt;
                cnt_d       = serial_ack ? '0 : cnt_inc;

                if (pending_nxt == '0) begin
                    if ((state_q == FLUSH) && op_has_clear(op_q)) begin
                        state_d   = CLEAR;
                        pending_d = mask_q;
                        cnt_d     = '0;
                    end else begin
                        state_d   = DONE;
                        cnt_d     = '0;
                    end
                end else if (TIMEOUT_EN && !serial_ack && (cnt_inc == CNT_MAX)) begin
                    state_d   = DONE;
                    pending_d = '0;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d   = IDLE;
                pending_d = '0;
                cnt_d     = '0;
            end
        endcase
    end

    // Registered outputs follow the next state so they line up with it.
    always_comb begin
        req_sel       = SERIAL_MODE ? sel_first : pending_d;
        cache_flush_d = (state_d == FLUSH) ? req_sel : '0;
        cache_clear_d = (state_d == CLEAR) ? req_sel : '0;
        done_d        = (state_d == DONE);
        busy_d        = (state_d != IDLE);
        req_ready_d   = (state_d == IDLE);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= IDLE;
            op_q          <= CC_NONE;
            mask_q        <= '0;
            pending_q     <= '0;
            cnt_q         <= '0;
            req_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
            cache_flush_q <= '0;
            cache_clear_q <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            mask_q        <= mask_d;
            pending_q     <= pending_d;
            cnt_q         <= cnt_d;
            req_ready_q   <= req_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timeout_q     <= timeout_d;
            cache_flush_q <= cache_flush_d;
            cache_clear_q <= cache_clear_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = timeout_q;
    assign cache_flush = cache_flush_q;
    assign cache_clear = cache_clear_q;

endmodule

// File: tb/tb_cache_control_sequencer.sv
// Randomized bench: a timeline model predicts every output cycle of each maintenance op
// for a parallel 2-cache instance and a serial 4-cache instance.
module tb_cache_control_sequencer;

    localparam int T_PAR = 8;
    localparam int T_SER = 6;
    localparam int NEVER = 1000;

    logic clk = 1'b0;
    logic n_rst = 1'b1;

    logic       p_req_valid, p_req_ready, p_busy, p_done, p_timeout_err;
    logic [1:0] p_req_op, p_req_mask, p_cache_flush, p_cache_clear, p_flush_done, p_clear_done;

    logic       s_req_valid, s_req_ready, s_busy, s_done, s_timeout_err;
    logic [1:0] s_req_op;
    logic [3:0] s_req_mask, s_cache_flush, s_cache_clear, s_flush_done, s_clear_done;

    int n_vec = 0;
    int n_err = 0;
    int g_cyc = 0;
    int g_txn = 0;

    // Expected request levels and acks to drive, per phase and per cycle of a transaction.
    logic [3:0] m_req [2][64];
    logic [3:0] m_ack [2][64];
    int         m_t;
    bit         m_to;
    int         g_fd [4];
    int         g_cd [4];

    always #5 clk = ~clk;

    cache_control_sequencer #(
        .NUM_CACHES (2), .SERIAL (0), .TIMEOUT_CYCLES (T_PAR)
    ) u_par (
        .CLK (clk), .nRST (n_rst),
        .req_valid (p_req_valid), .req_op (p_req_op), .req_mask (p_req_mask),
        .req_ready (p_req_ready), .busy (p_busy), .done (p_done), .timeout_err (p_timeout_err),
        .cache_flush (p_cache_flush), .cache_clear (p_cache_clear),
        .flush_done (p_flush_done), .clear_done (p_clear_done)
    );

    cache_control_sequencer #(
        .NUM_CACHES (4), .SERIAL (1), .TIMEOUT_CYCLES (T_SER)
    ) u_ser (
        .CLK (clk), .nRST (n_rst),
        .req_valid (s_req_valid), .req_op (s_req_op), .req_mask (s_req_mask),
        .req_ready (s_req_ready), .busy (s_busy), .done (s_done), .timeout_err (s_timeout_err),
        .cache_flush (s_cache_flush), .cache_clear (s_cache_clear),
        .flush_done (s_flush_done), .clear_done (s_clear_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s txn%0d cyc%0d: got 0x%0h expected 0x%0h", tag, g_txn, g_cyc, got, exp);
        end
    endtask

    task automatic drive(input bit ser, input logic v, input logic [1:0] op, input logic [3:0] m,
                         input logic [3:0] fa, input logic [3:0] ca);
        if (ser) begin
            s_req_valid = v; s_req_op = op; s_req_mask = m; s_flush_done = fa; s_clear_done = ca;
            p_req_valid = 1'b0; p_req_op = 2'b00; p_req_mask = 2'b00;
            p_flush_done = 2'b00; p_clear_done = 2'b00;
        end else begin
            p_req_valid = v; p_req_op = op; p_req_mask = m[1:0];
            p_flush_done = fa[1:0]; p_clear_done = ca[1:0];
            s_req_valid = 1'b0; s_req_op = 2'b00; s_req_mask = 4'h0;
            s_flush_done = 4'h0; s_clear_done = 4'h0;
        end
    endtask

    task automatic observe(input bit ser, input logic [3:0] ef, input logic [3:0] ec,
                           input logic ed, input logic et, input logic eb, input logic er);
        check(ser ? "s_cache_flush" : "p_cache_flush", 32'(ser ? s_cache_flush : {2'b00, p_cache_flush}), 32'(ef));
        check(ser ? "s_cache_clear" : "p_cache_clear", 32'(ser ? s_cache_clear : {2'b00, p_cache_clear}), 32'(ec));
        check(ser ? "s_done" : "p_done",               32'(ser ? s_done : p_done),               32'(ed));
        check(ser ? "s_timeout_err" : "p_timeout_err", 32'(ser ? s_timeout_err : p_timeout_err), 32'(et));
        check(ser ? "s_busy" : "p_busy",               32'(ser ? s_busy : p_busy),               32'(eb));
        check(ser ? "s_req_ready" : "p_req_ready",     32'(ser ? s_req_ready : p_req_ready),     32'(er));
    endtask

    task automatic sample_check(input bit ser, input logic [3:0] ef, input logic [3:0] ec,
                                input logic ed, input logic et, input logic eb, input logic er);
        @(negedge clk);
        observe(ser, ef, ec, ed, et, eb, er);
    endtask

    // Timeline of one phase: parallel caches each hold their request until their own ack;
    // serial caches are served lowest index first, each for (delay+1) cycles.
    task automatic model_phase(input int p, input bit ser, input logic [3:0] mask, input int tmo);
        int d [4];
        int mx;
        int len;
        for (int i = 0; i < 4; i++) d[i] = (p == 0) ? g_fd[i] : g_cd[i];
        if (!ser) begin
            mx = -1;
            for (int i = 0; i < 4; i++) if (mask[i] && d[i] > mx) mx = d[i];
            len = (mx < tmo) ? mx + 1 : tmo;
            if (mx >= tmo) m_to = 1'b1;
            for (int k = 0; k < len; k++)
                for (int i = 0; i < 4; i++)
                    if (mask[i] && d[i] >= k) m_req[p][m_t + k][i] = 1'b1;
            for (int i = 0; i < 4; i++)
                if (mask[i] && d[i] < len) m_ack[p][m_t + d[i]][i] = 1'b1;
            m_t += len;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (mask[i] && !m_to) begin
                    len = (d[i] < tmo) ? d[i] + 1 : tmo;
                    for (int k = 0; k < len; k++) m_req[p][m_t + k][i] = 1'b1;
                    if (d[i] < tmo) m_ack[p][m_t + d[i]][i] = 1'b1;
                    else            m_to = 1'b1;
                    m_t += len;
                end
            end
        end
    endtask

    task automatic run_txn(input bit ser, input logic [1:0] op, input logic [3:0] mask_in, input bit spur);
        logic [3:0] mask;
        logic [3:0] sf;
        logic [3:0] sc;
        logic       jv;
        int         tmo;
        int         e;
        g_txn++;
        mask = mask_in & (ser ? 4'hF : 4'h3);
        tmo  = ser ? T_SER : T_PAR;
        for (int k = 0; k < 64; k++) begin
            m_req[0][k] = 4'h0; m_req[1][k] = 4'h0;
            m_ack[0][k] = 4'h0; m_ack[1][k] = 4'h0;
        end
        m_t  = 1;
        m_to = 1'b0;
        if (op[0] && mask != 4'h0) model_phase(0, ser, mask, tmo);
        if (!m_to && op[1] && mask != 4'h0) model_phase(1, ser, mask, tmo);
        e = m_t;

        @(posedge clk); #1;
        g_cyc = 0;
        drive(ser, 1'b1, op, mask, 4'h0, 4'h0);
        sample_check(ser, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= e; k++) begin
            @(posedge clk); #1;
            g_cyc = k;
            jv = spur && ($urandom_range(0, 2) == 0);
            sf = spur ? (4'($urandom) & ~m_req[0][k]) : 4'h0;
            sc = spur ? (4'($urandom) & ~m_req[1][k]) : 4'h0;
            drive(ser, jv, 2'($urandom), 4'($urandom), m_ack[0][k] | sf, m_ack[1][k] | sc);
            sample_check(ser, m_req[0][k], m_req[1][k], 1'(k == e), 1'((k == e) && m_to), 1'b1, 1'b0);
        end
    endtask

    task automatic idle_check(input bit ser);
        @(posedge clk); #1;
        g_cyc = -1;
        drive(ser, 1'b0, 2'b00, 4'h0, 4'h0, 4'h0);
        sample_check(ser, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    function automatic int rand_delay(input int tmo);
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return NEVER;
        if (r < 6)  return int'($urandom_range(0, 2));
        return int'($urandom_range(0, tmo - 1));
    endfunction

    initial begin
        bit         ser;
        logic [3:0] m;
        drive(1'b0, 1'b0, 2'b00, 4'h0, 4'h0, 4'h0);
        #1 n_rst = 1'b0;
        #1;
        g_cyc = -1;
        observe(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        observe(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk) n_rst = 1'b1;

        // Flush acked two cycles into the request, clears acked at different times.
        g_fd = '{1, 1, 0, 0}; g_cd = '{0, 2, 0, 0};
        run_txn(1'b0, 2'b11, 4'b0011, 1'b0);
        // Serial flush walks cache 1 then cache 3.
        g_fd = '{0, 2, 0, 3}; g_cd = '{0, 0, 0, 0};
        run_txn(1'b1, 2'b01, 4'b1010, 1'b0);
        // Degenerate requests complete without touching any cache.
        run_txn(1'b0, 2'b00, 4'b0011, 1'b0);
        run_txn(1'b0, 2'b01, 4'b0000, 1'b0);
        run_txn(1'b1, 2'b11, 4'b0000, 1'b0);
        // Cache 1 never acknowledges the flush: timeout, clear phase skipped.
        g_fd = '{0, NEVER, 0, 0}; g_cd = '{0, 0, 0, 0};
        run_txn(1'b0, 2'b11, 4'b0011, 1'b0);
        g_fd = '{0, NEVER, 0, 0};
        run_txn(1'b1, 2'b11, 4'b0110, 1'b0);
        // Final ack on the last allowed cycle beats the timeout.
        g_fd = '{3, T_PAR - 1, 0, 0};
        run_txn(1'b0, 2'b01, 4'b0011, 1'b0);
        g_fd = '{T_SER - 1, 0, T_SER - 1, 0}; g_cd = '{0, 0, 0, 0};
        run_txn(1'b1, 2'b01, 4'b0101, 1'b0);
        // Spurious and wrong-phase acks during a flush.
        g_fd = '{3, 0, 0, 0}; g_cd = '{1, 1, 1, 1};
        run_txn(1'b0, 2'b11, 4'b0001, 1'b1);
        g_fd = '{2, 0, 2, 0}; g_cd = '{1, 0, 1, 0};
        run_txn(1'b1, 2'b11, 4'b0101, 1'b1);

        // Reset in the middle of a clear phase.
        @(posedge clk); #1;
        g_txn++;
        g_cyc = 0;
        drive(1'b0, 1'b1, 2'b10, 4'b0011, 4'h0, 4'h0);
        @(posedge clk); #1;
        g_cyc = 1;
        drive(1'b0, 1'b0, 2'b00, 4'h0, 4'h0, 4'h0);
        @(posedge clk); #1;
        g_cyc = 2;
        sample_check(1'b0, 4'h0, 4'b0011, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 n_rst = 1'b0;
        #1;
        observe(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1 n_rst = 1'b1;
        g_cd = '{1, 0, 0, 0};
        run_txn(1'b0, 2'b10, 4'b0011, 1'b0);

        for (int i = 0; i < 60; i++) begin
            ser = (i % 2) == 1;
            m   = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            for (int j = 0; j < 4; j++) begin
                g_fd[j] = rand_delay(ser ? T_SER : T_PAR);
                g_cd[j] = rand_delay(ser ? T_SER : T_PAR);
            end
            run_txn(ser, 2'($urandom), m, 1'b1);
            if ($urandom_range(0, 3) == 0) idle_check(ser);
        end
        idle_check(1'b0);
        idle_check(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
